// File: rtl/ce_gen_multi.sv
// ce_gen_multi: multi-channel fractional clock-enable generator.
// Each channel runs a phase accumulator clocked by refclk and strobes ce on
// accumulator overflow. Per-channel step/phase updates arrive through a
// single-slot valid/ready port. An update is applied on the channel's next
// overflow, so the output cadence never glitches. If the channel is idle,
// the update is applied at once. A lock indication reports when all updates
// have settled.
module ce_gen_multi #(
    parameter int                         NUM_CH      = 3,
    parameter int                         ACC_W       = 32,
    parameter logic [NUM_CH*ACC_W-1:0]    DEF_STEP    = {32'h5555_5556, 32'h0AAA_AAAB, 32'h0AAA_AAAB},
    parameter logic [NUM_CH*ACC_W-1:0]    DEF_PHASE   = '0,
    parameter int                         LOCK_CYCLES = 16,
    parameter int                         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_step,
    input  logic [ACC_W-1:0]    cfg_phase,
    output logic [NUM_CH-1:0]   ce,
    output logic                locked
);

    localparam int              CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        COUNT    = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    // channel state
    logic [ACC_W-1:0]   acc_r   [NUM_CH];
    logic [ACC_W-1:0]   step_r  [NUM_CH];
    logic [ACC_W-1:0]   acc_s   [NUM_CH];
    logic [ACC_W-1:0]   step_s  [NUM_CH];
    logic [ACC_W:0]     sum_s   [NUM_CH];
    logic [NUM_CH-1:0]  ce_r;
    logic [NUM_CH-1:0]  ce_s;
    logic [NUM_CH-1:0]  apply_s;

    // pending config slot
    logic               pending_r;
    logic               pending_s;
    logic [CH_W-1:0]    pend_ch_r;
    logic [ACC_W-1:0]   pend_step_r;
    logic [ACC_W-1:0]   pend_phase_r;
    logic               cfg_ready_r;
    logic               accept_s;
    logic               capture_s;
    logic               apply_any_s;

    // lock tracking
    lock_state_t        state_r;
    lock_state_t        state_s;
    logic [CNT_W-1:0]   lock_cnt_r;
    logic [CNT_W-1:0]   lock_cnt_s;
    logic               locked_r;

    assign accept_s    = cfg_valid && cfg_ready_r;
    assign capture_s   = accept_s && ({1'b0, cfg_ch} < NUM_CH_V);
    assign apply_any_s = |apply_s;

    // Accumulator sums and the boundary at which the pending update may land.
    always_comb begin
        apply_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_s[i] = {1'b0, acc_r[i]} + {1'b0, step_r[i]};
            if (pending_r && (pend_ch_r == CH_W'(i))) begin
                apply_s[i] = !enable[i] || (step_r[i] == {ACC_W{1'b0}}) || sum_s[i][ACC_W];
            end else begin
                apply_s[i] = 1'b0;
            end
        end
    end

    // Next accumulator/step/strobe per channel; an applied update keeps the boundary strobe.
    always_comb begin
        ce_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_s[i]  = acc_r[i];
            step_s[i] = step_r[i];
            if (apply_s[i]) begin
                acc_s[i]  = pend_phase_r;
                step_s[i] = pend_step_r;
                ce_s[i]   = enable[i] && sum_s[i][ACC_W];
            end else if (enable[i]) begin
                acc_s[i]  = sum_s[i][ACC_W-1:0];
                ce_s[i]   = sum_s[i][ACC_W];
            end else begin
                ce_s[i]   = 1'b0;
            end
        end
    end

    // Pending slot occupancy: set by a captured request, cleared by its apply.
    always_comb begin
        pending_s = pending_r;
        if (capture_s) begin
            pending_s = 1'b1;
        end else if (apply_any_s) begin
            pending_s = 1'b0;
        end else begin
            pending_s = pending_r;
        end
    end

    // Lock FSM next state: accepted configs restart the quiet-time count.
    always_comb begin
        state_s    = state_r;
        lock_cnt_s = lock_cnt_r;
        case (state_r)
            UNLOCKED: begin
                if (capture_s) begin
                    state_s = UNLOCKED;
                end else if (!pending_r || apply_any_s) begin
                    state_s    = COUNT;
                    lock_cnt_s = '0;
                end else begin
                    state_s = UNLOCKED;
                end
            end
            COUNT: begin
                if (capture_s) begin
                    state_s    = UNLOCKED;
                    lock_cnt_s = '0;
                end else if (lock_cnt_r == CNT_LAST) begin
                    state_s = LOCKED;
                end else begin
                    lock_cnt_s = lock_cnt_r + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (capture_s) begin
                    state_s    = UNLOCKED;
                    lock_cnt_s = '0;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s    = UNLOCKED;
                lock_cnt_s = '0;
            end
        endcase
    end

    // Channel registers and strobe outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_r[i]  <= DEF_PHASE[i*ACC_W +: ACC_W];
                step_r[i] <= DEF_STEP[i*ACC_W +: ACC_W];
            end
            ce_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_r[i]  <= acc_s[i];
                step_r[i] <= step_s[i];
            end
            ce_r <= ce_s;
        end
    end

    // Config slot registers and the registered ready flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r    <= 1'b0;
            pend_ch_r    <= '0;
            pend_step_r  <= '0;
            pend_phase_r <= '0;
            cfg_ready_r  <= 1'b0;
        end else begin
            pending_r   <= pending_s;
            cfg_ready_r <= !pending_s;
            if (capture_s) begin
                pend_ch_r    <= cfg_ch;
                pend_step_r  <= cfg_step;
                pend_phase_r <= cfg_phase;
            end
        end
    end

    // Lock FSM state, counter and registered lock flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= UNLOCKED;
            lock_cnt_r <= '0;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            lock_cnt_r <= lock_cnt_s;
            locked_r   <= (state_s == LOCKED);
        end
    end

    assign ce        = ce_r;
    assign cfg_ready = cfg_ready_r;
    assign locked    = locked_r;

endmodule

// File: tb/tb_ce_gen_multi.sv
// Bench for ce_gen_multi: a fixed vector table after reset, hand-written
// handshake/apply sequences, and a randomized run. An arithmetic reference
// model checks every cycle.
module tb_ce_gen_multi;

    localparam int NUM_CH      = 3;
    localparam int ACC_W       = 32;
    localparam int LOCK_CYCLES = 16;
    localparam logic [31:0] DEF_S0 = 32'h0AAA_AAAB;
    localparam logic [31:0] DEF_S2 = 32'h5555_5556;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic [2:0]  enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_step;
    logic [31:0] cfg_phase;
    logic [2:0]  ce;
    logic        locked;

    ce_gen_multi #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES)) dut (
        .refclk(refclk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_step(cfg_step), .cfg_phase(cfg_phase), .ce(ce), .locked(locked)
    );

    always #5 refclk = ~refclk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    bit [31:0] m_acc  [3];
    bit [31:0] m_step [3];
    bit        m_pend;
    int        m_pch;
    bit [31:0] m_pstep, m_pphase;
    bit [2:0]  m_ce;
    bit        m_ready, m_locked;
    int        m_cyc, m_settle, m_applies;

    typedef struct {
        int         cyc;
        logic [2:0] ce;
        logic       ready;
        logic       locked;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_acc[i] = 32'h0;
        m_step[0] = DEF_S0; m_step[1] = DEF_S0; m_step[2] = DEF_S2;
        m_pend = 1'b0; m_ce = 3'b000; m_ready = 1'b0; m_locked = 1'b0;
        m_cyc = 0; m_settle = 1;
    endtask

    // One refclk edge of the behaviour: overflow strobes, pending apply, lock timing.
    task automatic model_step();
        bit [32:0] sum;
        bit        apply, acc_ok;
        acc_ok = cfg_valid && m_ready;
        apply  = 1'b0;
        if (m_pend) begin
            sum   = {1'b0, m_acc[m_pch]} + {1'b0, m_step[m_pch]};
            apply = !enable[m_pch] || (m_step[m_pch] == 32'h0) || sum[32];
        end
        for (int i = 0; i < 3; i++) begin
            sum = {1'b0, m_acc[i]} + {1'b0, m_step[i]};
            if (apply && i == m_pch) begin
                m_ce[i]   = enable[i] && sum[32];
                m_acc[i]  = m_pphase;
                m_step[i] = m_pstep;
            end else if (enable[i]) begin
                m_ce[i]  = sum[32];
                m_acc[i] = sum[31:0];
            end else begin
                m_ce[i] = 1'b0;
            end
        end
        m_cyc++;
        if (apply) begin
            m_pend = 1'b0; m_settle = m_cyc; m_applies++;
        end
        if (acc_ok && cfg_ch < 2'd3) begin
            m_pend = 1'b1; m_pch = int'(cfg_ch); m_pstep = cfg_step; m_pphase = cfg_phase;
        end
        m_ready  = !m_pend;
        m_locked = !m_pend && ((m_cyc - m_settle) >= LOCK_CYCLES);
    endtask

    task automatic tick();
        model_step();
        @(posedge refclk);
        #1;
        check("outputs{ce,ready,locked}", {27'd0, ce, cfg_ready, locked},
              {27'd0, m_ce, m_ready, m_locked});
    endtask

    task automatic run_table();
        enable = 3'b111; cfg_valid = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            tick();
            for (int k = 0; k < 10; k++) begin
                if (tbl[k].cyc == c) begin
                    check("tbl_ce", {29'd0, ce}, {29'd0, tbl[k].ce});
                    check("tbl_ready", {31'd0, cfg_ready}, {31'd0, tbl[k].ready});
                    check("tbl_locked", {31'd0, locked}, {31'd0, tbl[k].locked});
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {27'd0, ce, cfg_ready, locked}, 32'd0);
    endtask

    initial begin
        int          guard, since, idx, found;
        logic        was_ready;
        logic [1:0]  bb_ch    [3];
        logic [31:0] bb_step  [3];
        logic [31:0] bb_phase [3];
        logic [3:0]  exp1;
        int          r;

        tbl[0] = '{1,  3'b000, 1'b1, 1'b0};
        tbl[1] = '{2,  3'b000, 1'b1, 1'b0};
        tbl[2] = '{3,  3'b100, 1'b1, 1'b0};
        tbl[3] = '{6,  3'b100, 1'b1, 1'b0};
        tbl[4] = '{16, 3'b000, 1'b1, 1'b0};
        tbl[5] = '{17, 3'b000, 1'b1, 1'b1};
        tbl[6] = '{18, 3'b100, 1'b1, 1'b1};
        tbl[7] = '{23, 3'b000, 1'b1, 1'b1};
        tbl[8] = '{24, 3'b111, 1'b1, 1'b1};
        tbl[9] = '{48, 3'b111, 1'b1, 1'b1};

        m_applies = 0;
        rst_n = 1'b0; enable = 3'b111; cfg_valid = 1'b0;
        cfg_ch = 2'd0; cfg_step = 32'h0; cfg_phase = 32'h0;
        model_reset();
        #22;
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        run_table();

        // A: ch2 -> step 1/2 while running; applies on ch2's next strobe.
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_step = 32'h8000_0000; cfg_phase = 32'h0;
        tick();
        cfg_valid = 1'b0;
        check("a_lock_drop", {31'd0, locked}, 32'd0);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            tick();
            if (ce[2] == 1'b1) found = 1;
        end
        check("a_apply_seen", found, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("a_ce2_every2", {31'd0, ce[2]}, (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        since = 4;
        while (!locked && since < 40) begin
            tick();
            since++;
        end
        check("a_relock_delay", since, 16);

        // B: idle channel update applies at once; cadence after re-enable.
        enable = 3'b101;
        tick();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_step = 32'h4000_0000; cfg_phase = 32'hC000_0000;
        tick();
        cfg_valid = 1'b0;
        check("b_ready_low", {31'd0, cfg_ready}, 32'd0);
        tick();
        check("b_no_ce1", {31'd0, ce[1]}, 32'd0);
        check("b_ready_back", {31'd0, cfg_ready}, 32'd1);
        enable = 3'b111;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("b_ce1_cadence", {31'd0, ce[1]}, (k % 4 == 0) ? 32'd1 : 32'd0);
        end

        // C: three writes with cfg_valid held high.
        bb_ch[0] = 2'd0; bb_step[0] = 32'h0100_0000; bb_phase[0] = 32'h0;
        bb_ch[1] = 2'd1; bb_step[1] = 32'h2000_0000; bb_phase[1] = 32'h1234_5678;
        bb_ch[2] = 2'd2; bb_step[2] = 32'hFFFF_FFFF; bb_phase[2] = 32'h0;
        idx = 0; guard = 0;
        r = m_applies;
        while (idx < 3 && guard < 400) begin
            cfg_valid = 1'b1; cfg_ch = bb_ch[idx]; cfg_step = bb_step[idx]; cfg_phase = bb_phase[idx];
            was_ready = cfg_ready;
            tick();
            guard++;
            if (was_ready) begin
                check("c_ready_drop", {31'd0, cfg_ready}, 32'd0);
                idx++;
            end
        end
        cfg_valid = 1'b0;
        check("c_writes_accepted", idx, 3);
        guard = 0;
        while (!cfg_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("c_drain", {31'd0, cfg_ready}, 32'd1);
        check("c_applies", m_applies - r, 3);

        // D: out-of-range channel is swallowed without disturbing lock.
        guard = 0;
        while (!locked && guard < 60) begin
            tick();
            guard++;
        end
        check("d_locked_before", {31'd0, locked}, 32'd1);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_step = 32'h0000_0001; cfg_phase = 32'hFFFF_0000;
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("d_ready_stays", {31'd0, cfg_ready}, 32'd1);
            check("d_locked_stays", {31'd0, locked}, 32'd1);
            tick();
        end

        // E: reset while an update is pending.
        guard = 0;
        while (m_acc[0] >= 32'hE000_0000 && guard < 600) begin
            tick();
            guard++;
        end
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_step = 32'h0000_0001; cfg_phase = 32'h0;
        tick();
        cfg_valid = 1'b0;
        tick();
        check("e_pending_held", {31'd0, cfg_ready}, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("e_async_reset");
        @(posedge refclk);
        #1;
        check_reset_outputs("e_reset_hold");
        rst_n = 1'b1;
        run_table();

        // Randomized run against the model.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                exp1 = 4'($urandom_range(0, 2));
                enable[exp1[1:0]] = ~enable[exp1[1:0]];
            end
            if (!cfg_valid && $urandom_range(0, 5) == 0) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       cfg_step = 32'h0;
                    1:       cfg_step = 32'hFFFF_FFFF;
                    2:       cfg_step = $urandom >> 4;
                    default: cfg_step = $urandom;
                endcase
                cfg_phase = $urandom;
            end
            was_ready = cfg_ready;
            tick();
            if (cfg_valid && was_ready) cfg_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
